countdown_timer: RTL and testbench

- Loadable down-counter/timer: the decrementing counterpart of the team's up-counter.
- It counts a loaded value down to zero on enabled cycles.
- At terminal count it flags a one-cycle terminal pulse and either stops or auto-reloads.
- Sits beside the up-counters as the timeout/interval generator for board-level designs such as LED blink, UART bit timing and watchdogs.

---
 rtl/countdown_timer_pkg.sv | 15 +
 rtl/countdown_timer_if.sv | 35 +++
 rtl/countdown_timer_dec_borrow.sv | 50 +++++
 rtl/countdown_timer.sv | 99 +++++++++
 tb/tb_countdown_timer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer.
// Contents:
//   DEFAULT_WIDTH - default counter / load-value width in bits
//   state_t       - timer state encoding (IDLE, RUN, DONE)
package countdown_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle for the countdown timer.
// Signals:
//   LOAD - load D into count and reload register
//   D    - load value (unsigned, WIDTH bits)
//   EN   - count enable
//   AUTO - 1 = reload at terminal count, 0 = stop at zero
//   O    - current count
//   TC   - one-cycle terminal-count pulse
//   BUSY - high while counting
//   ZERO - high when O == 0
// Modports: master drives the controls, slave is the timer itself.
interface countdown_timer_if #(
  parameter int WIDTH = countdown_timer_pkg::DEFAULT_WIDTH
);

  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic             EN;
  logic             AUTO;
  logic [WIDTH-1:0] O;
  logic             TC;
  logic             BUSY;
  logic             ZERO;

  modport master (
    output LOAD, D, EN, AUTO,
    input  O, TC, BUSY, ZERO
  );

  modport slave (
    input  LOAD, D, EN, AUTO,
    output O, TC, BUSY, ZERO
  );

endinterface

// File: rtl/countdown_timer_dec_borrow.sv
// Ripple decrementer built from full-adder cells.
// full_adder ports:
//   a, b, cin - addend bits and carry in
//   sum, cout - sum bit and carry out
// dec_borrow ports:
//   value  - WIDTH-bit operand
//   diff   - value - 1 (modulo 2**WIDTH)
//   borrow - high when value == 0 (the subtraction underflowed)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module dec_borrow
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  // Adding all ones is subtracting one; the final carry is set for any
  // non-zero operand, so its absence means the decrement borrowed.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder fa (
      .a   (value[i]),
      .b   (1'b1),
      .cin (carry[i]),
      .sum (diff[i]),
      .cout(carry[i+1])
    );
  end

  assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter / interval timer.
// Counts a loaded value down to zero on enabled cycles, pulses TC for one
// cycle at terminal count, then either stops (DONE) or reloads (AUTO).
// Ports:
//   CLK    - clock, all state changes on the rising edge
//   RESETN - asynchronous active-low reset
//   bus    - slave side of countdown_timer_if (LOAD, D, EN, AUTO in;
//            O, TC, BUSY, ZERO out)
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           CLK,
  input  logic           RESETN,
  countdown_timer_if.slave bus
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_next;
  logic             tc;
  logic             tc_next;
  logic [WIDTH-1:0] dec;
  logic             borrow;
  logic             at_one;

  dec_borrow #(.WIDTH(WIDTH)) u_dec (
    .value (count),
    .diff  (dec),
    .borrow(borrow)
  );

  // count == 1 exactly when the decrement lands on zero without borrowing.
  assign at_one = ~borrow && (dec == '0);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      tc     <= tc_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    tc_next     = 1'b0;
    if (bus.LOAD) begin
      count_next  = bus.D;
      reload_next = bus.D;
      state_next  = (bus.D != '0) ? RUN : IDLE;
    end else begin
      unique case (state)
        RUN: begin
          // A zero count never reaches the decrementer output, so O
          // cannot wrap even if RUN were somehow entered with zero.
          if (bus.EN && !borrow) begin
            if (at_one) begin
              tc_next = 1'b1;
              if (bus.AUTO) begin
                count_next = reload;
              end else begin
                count_next = '0;
                state_next = DONE;
              end
            end else begin
              count_next = dec;
            end
          end
        end
        IDLE, DONE: begin
          state_next = state;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.O    = count;
    bus.TC   = tc;
    bus.BUSY = (state == RUN);
    bus.ZERO = (count == '0);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with
// hand-derived expectations plus a randomized run checked against a
// behavioural model of the timer.
module tb_countdown_timer;

  localparam int W = 4;

  logic CLK;
  logic RESETN;
  int   tests_run;
  int   tests_failed;

  // Behavioural model: the count, the reload value, whether counting is
  // active, and the terminal pulse.
  int   m_o;
  int   m_rel;
  bit   m_run;
  bit   m_tc;

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESETN(RESETN),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_o   = 0;
    m_rel = 0;
    m_run = 0;
    m_tc  = 0;
  endtask

  task automatic model_edge(input bit load, input int d, input bit en, input bit auto_r);
    m_tc = 0;
    if (load) begin
      m_o   = d;
      m_rel = d;
      m_run = (d != 0);
    end else if (m_run && en) begin
      if (m_o == 1) begin
        m_tc = 1;
        if (auto_r) begin
          m_o = m_rel;
        end else begin
          m_o   = 0;
          m_run = 0;
        end
      end else begin
        m_o = m_o - 1;
      end
    end
  endtask

  // Advance one rising edge, update the model with the applied inputs,
  // and leave time 1 unit past the edge for sampling and driving.
  task automatic step();
    @(posedge CLK);
    if (!RESETN) model_reset();
    else model_edge(bus.LOAD, int'(bus.D), bus.EN, bus.AUTO);
    #1;
  endtask

  task automatic drive(input bit load, input int d, input bit en, input bit auto_r);
    bus.LOAD = load;
    bus.D    = d[W-1:0];
    bus.EN   = en;
    bus.AUTO = auto_r;
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    drive(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (bus.O !== 4'd0 || bus.TC !== 1'b0 || bus.BUSY !== 1'b0 || bus.ZERO !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL reset_hold[%0d]: O=%0d TC=%b BUSY=%b ZERO=%b, required O=0 TC=0 BUSY=0 ZERO=1",
                 i, bus.O, bus.TC, bus.BUSY, bus.ZERO);
      end
    end
    RESETN = 1'b1;
    drive(1, 7, 0, 0);
    step();
    tests_run++;
    if (bus.O !== 4'd7 || bus.BUSY !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_load: O=%0d BUSY=%b, required O=7 BUSY=1", bus.O, bus.BUSY);
    end
    drive(0, 0, 0, 0);
    #2 RESETN = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (bus.O !== 4'd0 || bus.BUSY !== 1'b0 || bus.ZERO !== 1'b1 || bus.TC !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_async: O=%0d BUSY=%b ZERO=%b TC=%b, required O=0 BUSY=0 ZERO=1 TC=0",
               bus.O, bus.BUSY, bus.ZERO, bus.TC);
    end
    #1 RESETN = 1'b1;
  endtask

  task automatic test_one_shot();
    int exp_o[9]    = '{3, 2, 1, 0, 0, 0, 0, 0, 0};
    bit exp_tc[9]   = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    bit exp_busy[9] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      drive(i == 0, 3, 1, 0);
      step();
      tests_run++;
      if (bus.O !== exp_o[i][W-1:0] || bus.TC !== exp_tc[i] || bus.BUSY !== exp_busy[i] ||
          bus.ZERO !== (exp_o[i] == 0)) begin
        tests_failed++;
        $display("[TB] FAIL one_shot[%0d]: O=%0d TC=%b BUSY=%b ZERO=%b, required O=%0d TC=%b BUSY=%b",
                 i, bus.O, bus.TC, bus.BUSY, bus.ZERO, exp_o[i], exp_tc[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_auto_reload();
    int exp_o[5]  = '{2, 1, 2, 1, 2};
    bit exp_tc[5] = '{0, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) begin
      drive(i == 0, 2, 1, 1);
      step();
      tests_run++;
      if (bus.O !== exp_o[i][W-1:0] || bus.TC !== exp_tc[i] || bus.BUSY !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL auto_reload[%0d]: O=%0d TC=%b BUSY=%b, required O=%0d TC=%b BUSY=1",
                 i, bus.O, bus.TC, bus.BUSY, exp_o[i], exp_tc[i]);
      end
    end
  endtask

  task automatic test_enable_gating();
    bit en_pat[6] = '{0, 1, 0, 0, 1, 1};
    int exp_o[6]  = '{5, 4, 4, 4, 3, 2};
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, 5, en_pat[i], 0);
      step();
      tests_run++;
      if (bus.O !== exp_o[i][W-1:0] || bus.TC !== 1'b0 || bus.BUSY !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL enable_gating[%0d]: O=%0d TC=%b BUSY=%b, required O=%0d TC=0 BUSY=1",
                 i, bus.O, bus.TC, bus.BUSY, exp_o[i]);
      end
    end
  endtask

  task automatic test_load_collision();
    drive(1, 2, 1, 0);
    step();
    drive(0, 0, 1, 0);
    step();
    tests_run++;
    if (bus.O !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL collision_setup: O=%0d, required O=1", bus.O);
    end
    drive(1, 9, 1, 0);
    step();
    tests_run++;
    if (bus.O !== 4'd9 || bus.TC !== 1'b0 || bus.BUSY !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL collision_load: O=%0d TC=%b BUSY=%b, required O=9 TC=0 BUSY=1",
               bus.O, bus.TC, bus.BUSY);
    end
    drive(1, 0, 1, 0);
    step();
    tests_run++;
    if (bus.O !== 4'd0 || bus.TC !== 1'b0 || bus.BUSY !== 1'b0 || bus.ZERO !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL load_zero: O=%0d TC=%b BUSY=%b ZERO=%b, required O=0 TC=0 BUSY=0 ZERO=1",
               bus.O, bus.TC, bus.BUSY, bus.ZERO);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 1);
      step();
      tests_run++;
      if (bus.O !== 4'd0 || bus.TC !== 1'b0 || bus.BUSY !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL idle_hold[%0d]: O=%0d TC=%b BUSY=%b, required O=0 TC=0 BUSY=0",
                 i, bus.O, bus.TC, bus.BUSY);
      end
    end
  endtask

  task automatic test_max_and_reset();
    int edges = 0;
    bit seen  = 0;
    drive(1, 15, 1, 0);
    step();
    tests_run++;
    if (bus.O !== 4'd15) begin
      tests_failed++;
      $display("[TB] FAIL max_load: O=%0d, required O=15", bus.O);
    end
    drive(0, 0, 1, 0);
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      edges++;
      if (bus.TC === 1'b1) seen = 1;
    end
    tests_run++;
    if (!seen || edges != 15) begin
      tests_failed++;
      $display("[TB] FAIL max_latency: TC seen=%b after %0d edges, required TC after 15 edges",
               seen, edges);
    end
    drive(1, 15, 1, 0);
    step();
    drive(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step();
    tests_run++;
    if (bus.O !== 4'd6) begin
      tests_failed++;
      $display("[TB] FAIL midrun_count: O=%0d, required O=6", bus.O);
    end
    #2 RESETN = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (bus.O !== 4'd0 || bus.BUSY !== 1'b0 || bus.TC !== 1'b0 || bus.ZERO !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset: O=%0d BUSY=%b TC=%b ZERO=%b, required O=0 BUSY=0 TC=0 ZERO=1",
               bus.O, bus.BUSY, bus.TC, bus.ZERO);
    end
    #1 RESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (bus.O !== 4'd0 || bus.BUSY !== 1'b0 || bus.TC !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL post_reset[%0d]: O=%0d BUSY=%b TC=%b, required O=0 BUSY=0 TC=0",
                 i, bus.O, bus.BUSY, bus.TC);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      step();
      tests_run++;
      if (bus.O !== m_o[W-1:0] || bus.TC !== m_tc || bus.BUSY !== m_run ||
          bus.ZERO !== (m_o == 0)) begin
        tests_failed++;
        $display("[TB] FAIL random[%0d]: O=%0d TC=%b BUSY=%b ZERO=%b, required O=%0d TC=%b BUSY=%b ZERO=%b",
                 i, bus.O, bus.TC, bus.BUSY, bus.ZERO, m_o, m_tc, m_run, (m_o == 0));
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_reset();
    RESETN = 1'b0;
    drive(0, 0, 0, 0);
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_enable_gating();
    test_load_collision();
    test_max_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
